// File: rtl/sd_pkg.sv
// Shared types and default constants for the SD card clock generator.
package sd_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        PARKED    = 2'd1,
        RUN       = 2'd2
    } sd_state_e;

    localparam int SD_FAST_DIV  = 3;
    localparam int SD_SLOW_DIV  = 188;
    localparam int SD_DIV_W     = 8;
    localparam int SD_LOCK_WAIT = 1024;

endpackage

// File: rtl/sd_lock_qual.sv
// Synchronizes the asynchronous PLL lock and qualifies it with a
// saturating stability counter before declaring the clock ready.
module sd_lock_qual
    import sd_pkg::*;
#(
    parameter int LOCK_WAIT = SD_LOCK_WAIT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pll_lock_i,
    output logic lock_s_o,
    output logic ready_o
);

    localparam int CNT_W = $clog2(LOCK_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_WAIT);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    logic             ready_q;
    logic             ready_d;

    // Any low sample restarts the qualification window from zero.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!sync2_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != CNT_MAX) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
        ready_d = sync2_q && (lock_cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lock_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            sync1_q    <= pll_lock_i;
            sync2_q    <= sync1_q;
            lock_cnt_q <= lock_cnt_d;
            ready_q    <= ready_d;
        end
    end

    assign lock_s_o = sync2_q;
    assign ready_o  = ready_q;

endmodule

// File: rtl/sd_clk_gen.sv
// SD card clock generator: divides the PLL clock to the slow/fast SD rates
// with glitch-free switching, clean stop/start and edge strobes.
module sd_clk_gen
    import sd_pkg::*;
#(
    parameter int FAST_DIV  = SD_FAST_DIV,
    parameter int SLOW_DIV  = SD_SLOW_DIV,
    parameter int LOCK_WAIT = SD_LOCK_WAIT,
    parameter int DIV_W     = SD_DIV_W
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic fast_sel,
    input  logic stop_req,
    output logic sd_clk,
    output logic rise_stb,
    output logic fall_stb,
    output logic ready,
    output logic clk_active,
    output logic fast_active
);

    localparam logic [DIV_W-1:0] FAST_DIV_C = DIV_W'(FAST_DIV);
    localparam logic [DIV_W-1:0] SLOW_DIV_C = DIV_W'(SLOW_DIV);

    sd_state_e        state_q;
    sd_state_e        state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] half;
    logic             fast_q;
    logic             fast_d;
    logic             sd_clk_q;
    logic             sd_clk_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             lock_s;
    logic             period_end;
    logic             start_period;

    sd_lock_qual #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qual (
        .clk_i      (clk),
        .reset_i    (reset),
        .pll_lock_i (pll_lock),
        .lock_s_o   (lock_s),
        .ready_o    (ready)
    );

    assign half       = div_q >> 1;
    assign period_end = (cnt_q == (div_q - DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Losing lock overrides everything; stopping only happens at a period boundary.
    always_comb begin
        state_d = state_q;
        if (!lock_s) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: if (ready) state_d = PARKED;
                PARKED:    if (!stop_req) state_d = RUN;
                RUN:       if (period_end && stop_req) state_d = PARKED;
                default:   state_d = WAIT_LOCK;
            endcase
        end
    end

    // The divisor is only re-latched at a period start, so phases are never shortened.
    always_comb begin
        cnt_d        = '0;
        div_d        = div_q;
        fast_d       = fast_q;
        start_period = (state_d == RUN) && ((state_q != RUN) || period_end);
        if (start_period) begin
            div_d  = fast_sel ? FAST_DIV_C : SLOW_DIV_C;
            fast_d = fast_sel;
        end else if (state_d == RUN) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        clk_active = (state_q == RUN);
        sd_clk_d   = lock_s && (state_q == RUN) && (cnt_q < half);
        rise_d     = sd_clk_d && !sd_clk_q;
        fall_d     = !sd_clk_d && sd_clk_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            div_q    <= SLOW_DIV_C;
            fast_q   <= 1'b0;
            sd_clk_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            fast_q   <= fast_d;
            sd_clk_q <= sd_clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sd_clk      = sd_clk_q;
    assign rise_stb    = rise_q;
    assign fall_stb    = fall_q;
    assign fast_active = fast_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed self-checking bench for sd_clk_gen: lock qualification, slow/fast
// rates, rate switching, stop/start, lock loss and reset during RUN.
module tb_sd_clk_gen;

    logic clk = 1'b0;
    logic reset;
    logic pll_lock;
    logic fast_sel;
    logic stop_req;
    logic sd_clk;
    logic rise_stb;
    logic fall_stb;
    logic ready;
    logic clk_active;
    logic fast_active;

    int checks = 0;
    int errors = 0;
    int highCnt;
    int riseCnt;
    int fallCnt;
    int fallAt;
    int fastSeen;
    int sawHigh;
    int sawReady;

    typedef struct {
        logic fastSel;
        logic stopReq;
        logic expSdClk;
        logic expRise;
        logic expFall;
        logic expReady;
        logic expActive;
        logic expFast;
    } vec_t;

    vec_t vecs[21];

    always #5 clk = ~clk;

    sd_clk_gen dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .fast_sel    (fast_sel),
        .stop_req    (stop_req),
        .sd_clk      (sd_clk),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .ready       (ready),
        .clk_active  (clk_active),
        .fast_active (fast_active)
    );

    function automatic vec_t mkVec(input logic fs, input logic st, input logic sd, input logic r,
                                   input logic f, input logic rdy, input logic ca, input logic fa);
        vec_t v;
        v.fastSel   = fs;
        v.stopReq   = st;
        v.expSdClk  = sd;
        v.expRise   = r;
        v.expFall   = f;
        v.expReady  = rdy;
        v.expActive = ca;
        v.expFast   = fa;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fs, input logic st);
        fast_sel = fs;
        stop_req = st;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int sd, input int r, input int f,
                            input int rdy, input int ca, input int fa);
        checkOutput({tag, ".sd_clk"}, int'(sd_clk), sd);
        checkOutput({tag, ".rise_stb"}, int'(rise_stb), r);
        checkOutput({tag, ".fall_stb"}, int'(fall_stb), f);
        checkOutput({tag, ".ready"}, int'(ready), rdy);
        checkOutput({tag, ".clk_active"}, int'(clk_active), ca);
        checkOutput({tag, ".fast_active"}, int'(fast_active), fa);
    endtask

    // pll_lock must have just gone high with both synchronizer flops at 0.
    task automatic waitLock(input string tag);
        sawHigh  = 0;
        sawReady = 0;
        for (int i = 0; i < 1026; i++) begin
            tick();
            if (sd_clk) sawHigh = 1;
            if (ready) sawReady = 1;
        end
        checkOutput({tag, ".sd_clk_low_while_qualifying"}, sawHigh, 0);
        checkOutput({tag, ".ready_before_1027"}, sawReady, 0);
        tick();
        checkOutput({tag, ".ready_at_1027"}, int'(ready), 1);
    endtask

    initial begin
        // Switch at E377, fast periods, stop at cnt=0, restart, back to slow.
        vecs[0]  = mkVec(1, 0, 0, 0, 0, 1, 1, 1);
        vecs[1]  = mkVec(1, 0, 1, 1, 0, 1, 1, 1);
        vecs[2]  = mkVec(1, 0, 0, 0, 1, 1, 1, 1);
        vecs[3]  = mkVec(1, 0, 0, 0, 0, 1, 1, 1);
        vecs[4]  = mkVec(1, 0, 1, 1, 0, 1, 1, 1);
        vecs[5]  = mkVec(1, 0, 0, 0, 1, 1, 1, 1);
        vecs[6]  = mkVec(1, 0, 0, 0, 0, 1, 1, 1);
        vecs[7]  = mkVec(1, 1, 1, 1, 0, 1, 1, 1);
        vecs[8]  = mkVec(1, 1, 0, 0, 1, 1, 1, 1);
        vecs[9]  = mkVec(1, 1, 0, 0, 0, 1, 0, 1);
        vecs[10] = mkVec(1, 1, 0, 0, 0, 1, 0, 1);
        vecs[11] = mkVec(1, 1, 0, 0, 0, 1, 0, 1);
        vecs[12] = mkVec(1, 0, 0, 0, 0, 1, 1, 1);
        vecs[13] = mkVec(1, 0, 1, 1, 0, 1, 1, 1);
        vecs[14] = mkVec(1, 0, 0, 0, 1, 1, 1, 1);
        vecs[15] = mkVec(1, 0, 0, 0, 0, 1, 1, 1);
        vecs[16] = mkVec(1, 0, 1, 1, 0, 1, 1, 1);
        vecs[17] = mkVec(0, 0, 0, 0, 1, 1, 1, 1);
        vecs[18] = mkVec(0, 0, 0, 0, 0, 1, 1, 0);
        vecs[19] = mkVec(0, 0, 1, 1, 0, 1, 1, 0);
        vecs[20] = mkVec(0, 0, 1, 0, 0, 1, 1, 0);

        reset    = 1'b1;
        pll_lock = 1'b0;
        applyStimulus(1'b0, 1'b1);
        repeat (3) tick();
        checkAll("reset", 0, 0, 0, 0, 0, 0);

        reset    = 1'b0;
        pll_lock = 1'b1;
        waitLock("lock");

        repeat (3) tick();
        checkOutput("parked.clk_active", int'(clk_active), 0);
        checkOutput("parked.sd_clk", int'(sd_clk), 0);

        applyStimulus(1'b0, 1'b0);
        tick();
        checkAll("start.e1", 0, 0, 0, 1, 1, 0);
        tick();
        checkAll("start.e2", 1, 1, 0, 1, 1, 0);

        // One full slow period after the first rise.
        highCnt = 0; riseCnt = 0; fallCnt = 0; fallAt = -1;
        for (int i = 1; i <= 188; i++) begin
            tick();
            if (sd_clk) highCnt++;
            if (rise_stb) riseCnt++;
            if (fall_stb) begin
                fallCnt++;
                fallAt = i;
            end
        end
        checkOutput("slow.high_cycles", highCnt, 94);
        checkOutput("slow.rise_count", riseCnt, 1);
        checkOutput("slow.fall_count", fallCnt, 1);
        checkOutput("slow.fall_offset", fallAt, 94);
        checkOutput("slow.rise_at_period_end", int'(rise_stb), 1);

        // fast_sel rises 40 cycles into this slow period; it must complete unchanged.
        highCnt = 0; riseCnt = 0; fallCnt = 0; fastSeen = 0;
        for (int i = 1; i <= 186; i++) begin
            tick();
            if (sd_clk) highCnt++;
            if (rise_stb) riseCnt++;
            if (fall_stb) fallCnt++;
            if (fast_active) fastSeen = 1;
            if (i == 40) fast_sel = 1'b1;
        end
        checkOutput("switch.slow_high_cycles", highCnt, 93);
        checkOutput("switch.slow_rise_count", riseCnt, 0);
        checkOutput("switch.slow_fall_count", fallCnt, 1);
        checkOutput("switch.fast_active_early", fastSeen, 0);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].fastSel, vecs[i].stopReq);
            tick();
            checkAll($sformatf("vec%0d", i), int'(vecs[i].expSdClk), int'(vecs[i].expRise),
                     int'(vecs[i].expFall), int'(vecs[i].expReady), int'(vecs[i].expActive),
                     int'(vecs[i].expFast));
        end

        // Lock drop in the middle of a slow high phase.
        repeat (8) tick();
        checkOutput("lockloss.pre_high", int'(sd_clk), 1);
        pll_lock = 1'b0;
        tick();
        tick();
        checkOutput("lockloss.still_high", int'(sd_clk), 1);
        checkOutput("lockloss.still_ready", int'(ready), 1);
        tick();
        checkAll("lockloss", 0, 0, 1, 0, 0, 0);
        tick();
        checkOutput("lockloss.single_fall", int'(fall_stb), 0);
        checkOutput("lockloss.sd_clk_low", int'(sd_clk), 0);

        pll_lock = 1'b1;
        waitLock("relock");
        tick();
        checkOutput("relock.parked_active", int'(clk_active), 0);
        tick();
        checkAll("relock.run", 0, 0, 0, 1, 1, 0);
        tick();
        checkAll("relock.rise", 1, 1, 0, 1, 1, 0);

        repeat (5) tick();
        checkOutput("resetrun.pre_high", int'(sd_clk), 1);
        reset = 1'b1;
        tick();
        checkAll("resetrun", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        sawHigh = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sd_clk || rise_stb || fall_stb || ready) sawHigh = 1;
        end
        checkOutput("resetrun.quiet_after", sawHigh, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
